// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: two-requester round-robin front end
// onto a single-beat AXI4 master, one transaction in flight.
module axi_mem_arbiter #(
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic [1:0]                        req_valid,
  output logic [1:0]                        req_ready,
  input  logic [1:0]                        req_we,
  input  logic [2*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*C_M_AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [2*C_M_AXI_DATA_WIDTH/8-1:0] req_wstrb,
  output logic [1:0]                        rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic                              rsp_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            own_q, own_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            aw_pend_q, aw_pend_d;
  logic            w_pend_q, w_pend_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            gnt;
  logic            idle_ok;
  logic            accept;
  logic            aw_done;
  logic            w_done;

  always_comb begin
    gnt = 1'b0;
    unique case (req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_q;
      default: gnt = 1'b0;
    endcase
  end

  // Reset gates the combinational ready so nothing is offered mid-reset
  assign idle_ok = (state_q == IDLE) && !M_AXI_ARESET
                && req_valid[gnt];
  assign req_ready = {gnt, ~gnt} & {2{idle_ok}};
  assign accept    = idle_ok;

  assign aw_done = !aw_pend_q || M_AXI_AWREADY;
  assign w_done  = !w_pend_q  || M_AXI_WREADY;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    own_d     = own_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          last_d  = gnt;
          own_d   = gnt;
          addr_d  = gnt ? req_addr[AW +: AW]
                        : req_addr[0 +: AW];
          wdata_d = gnt ? req_wdata[DW +: DW]
                        : req_wdata[0 +: DW];
          wstrb_d = gnt ? req_wstrb[SW +: SW]
                        : req_wstrb[0 +: SW];
          if (req_we[gnt]) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        if (M_AXI_AWREADY) aw_pend_d = 1'b0;
        if (M_AXI_WREADY)  w_pend_d  = 1'b0;
        if (aw_done && w_done) begin
          aw_pend_d = 1'b0;
          w_pend_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          err_d   = |M_AXI_BRESP;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          err_d   = |M_AXI_RRESP;
          rdata_d = M_AXI_RDATA;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      own_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      own_q     <= own_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_AWVALID = (state_q == WR_ADDR_DATA) && aw_pend_q;
  assign M_AXI_WVALID  = (state_q == WR_ADDR_DATA) && w_pend_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARVALID = (state_q == RD_ADDR);
  assign M_AXI_RREADY  = (state_q == RD_DATA);

  assign rsp_valid = {own_q, ~own_q}
                   & {2{state_q == RESP}};
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: random requesters and AXI slave
// checked against a transaction-level reference model.
module tb_axi_mem_arbiter;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, awready, wvalid, wready;
  logic [DW-1:0]   wdata, rdata;
  logic [SW-1:0]   wstrb;
  logic [1:0]      bresp, rresp;
  logic            bvalid, bready, arvalid, arready;
  logic            rvalid, rready;

  axi_mem_arbiter #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // requester slots
  bit            has [2];
  bit            swe [2];
  logic [AW-1:0] sa  [2];
  logic [DW-1:0] sd  [2];
  logic [SW-1:0] ss  [2];
  bit            auto_req = 0;
  bit            refill = 0;

  // slave knobs: forced wait/resp, -1 = random
  int f_aw = 0, f_w = 0, f_ar = 0, f_b = 0, f_r = 0;
  int f_resp = 0;

  // transaction-level model
  bit            busy, exp_rsp, exp_err;
  int            last = 1;
  int            t_own;
  bit            t_we;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, exp_data, r_data;
  logic [SW-1:0] t_wstrb;
  bit            aw_seen, w_seen, ar_seen, wrote;
  bit            b_pend, r_pend;
  logic [1:0]    b_resp, r_resp;
  int            aw_wait, w_wait, ar_wait, b_wait, r_wait;
  int            aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  int            cyc, done, aw_cyc, w_cyc, b_hs;
  int            grants[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [1:0]    last_vec;
  logic [DW-1:0] last_data;
  bit            last_err;
  logic [AW-1:0] last_ar;

  function automatic int pick(input logic [1:0] v);
    if (v == 2'b11) return 1 - last;
    if (v[1]) return 1;
    return 0;
  endfunction

  function automatic int wsel(input int f);
    return (f >= 0) ? f : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [1:0] rsel();
    if (f_resp >= 0) return f_resp[1:0];
    return ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
  endfunction

  task automatic new_req(input int i);
    has[i] = 1;
    swe[i] = 1'($urandom_range(0, 1));
    sa[i]  = AW'($urandom_range(0, 7) * 8);
    sd[i]  = {$urandom, $urandom};
    ss[i]  = SW'($urandom);
  endtask

  task automatic drive_req();
    for (int i = 0; i < 2; i++) begin
      if (!has[i] && (refill ||
          (auto_req && $urandom_range(0, 2) == 0)))
        new_req(i);
      if (!has[i]) begin
        swe[i] = 1'($urandom_range(0, 1));
        sa[i]  = $urandom;
        sd[i]  = {$urandom, $urandom};
        ss[i]  = SW'($urandom);
      end
    end
    req_valid = {has[1], has[0]};
    req_we    = {swe[1], swe[0]};
    req_addr  = {sa[1], sa[0]};
    req_wdata = {sd[1], sd[0]};
    req_wstrb = {ss[1], ss[0]};
  endtask

  // one clock: entered and left just after a falling edge
  task automatic step();
    int g;
    logic [DW-1:0] w;
    drive_req();
    awready = awvalid && (aw_cnt >= aw_wait);
    wready  = wvalid && (w_cnt >= w_wait);
    arready = arvalid && (ar_cnt >= ar_wait);
    bvalid  = b_pend && (b_cnt >= b_wait);
    bresp   = b_pend ? b_resp : 2'b00;
    rvalid  = r_pend && (r_cnt >= r_wait);
    rresp   = r_pend ? r_resp : 2'b00;
    rdata   = r_pend ? r_data : {$urandom, $urandom};
    #1;
    chk("rsp_valid", rsp_valid,
        exp_rsp ? (1 << t_own) : 0);
    if (exp_rsp) begin
      chk("rsp_rdata", rsp_rdata, exp_data);
      chk("rsp_err", rsp_err, exp_err);
      last_vec  = rsp_valid;
      last_data = rsp_rdata;
      last_err  = rsp_err;
    end
    chk("req_ready", req_ready,
        (!busy && req_valid != 0) ?
        (1 << pick(req_valid)) : 0);
    chk("awvalid", awvalid, busy && t_we && !aw_seen);
    chk("wvalid", wvalid, busy && t_we && !w_seen);
    chk("arvalid", arvalid, busy && !t_we && !ar_seen);
    chk("bready", bready,
        busy && t_we && wrote && !exp_rsp);
    chk("rready", rready,
        busy && !t_we && ar_seen && !exp_rsp);
    if (awvalid) chk("awaddr", awaddr, t_addr);
    if (wvalid) begin
      chk("wdata", wdata, t_wdata);
      chk("wstrb", wstrb, t_wstrb);
    end
    if (arvalid) chk("araddr", araddr, t_addr);
    if (exp_rsp) begin
      busy = 0;
      exp_rsp = 0;
      done++;
    end
    if (bvalid && bready) begin
      b_pend = 0;
      b_hs++;
      exp_rsp = 1;
      exp_data = '0;
      exp_err = |b_resp;
    end else if (b_pend) b_cnt++;
    if (rvalid && rready) begin
      r_pend = 0;
      exp_rsp = 1;
      exp_data = r_data;
      exp_err = |r_resp;
    end else if (r_pend) r_cnt++;
    if (|(req_valid & req_ready)) begin
      g = pick(req_valid);
      last = g;
      t_own = g;
      t_we = swe[g];
      t_addr = sa[g];
      t_wdata = sd[g];
      t_wstrb = ss[g];
      has[g] = 0;
      busy = 1;
      {aw_seen, w_seen, ar_seen, wrote} = '0;
      aw_wait = wsel(f_aw);
      w_wait = wsel(f_w);
      ar_wait = wsel(f_ar);
      b_wait = wsel(f_b);
      r_wait = wsel(f_r);
      {aw_cnt, w_cnt, ar_cnt} = '0;
      b_hs = 0;
      grants.push_back(g);
    end
    if (awvalid && awready) begin
      aw_seen = 1;
      aw_cyc = cyc;
    end else if (awvalid) aw_cnt++;
    if (wvalid && wready) begin
      w_seen = 1;
      w_cyc = cyc;
    end else if (wvalid) w_cnt++;
    if (busy && t_we && aw_seen && w_seen && !wrote) begin
      wrote = 1;
      w = mem.exists(t_addr) ? mem[t_addr] : '0;
      for (int b = 0; b < SW; b++)
        if (t_wstrb[b]) w[8*b +: 8] = t_wdata[8*b +: 8];
      mem[t_addr] = w;
      b_pend = 1;
      b_resp = rsel();
      b_cnt = 0;
    end
    if (arvalid && arready) begin
      ar_seen = 1;
      last_ar = araddr;
      r_pend = 1;
      r_data = mem.exists(t_addr) ? mem[t_addr] : '0;
      r_resp = rsel();
      r_cnt = 0;
    end else if (arvalid) ar_cnt++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int n);
    int lim = 0;
    while (done < n && lim < 300) begin
      step();
      lim++;
    end
    chk("timeout", done >= n, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_req();
    {awready, wready, arready} = '0;
    {bvalid, rvalid} = '0;
    @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready,
        rready, rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_addr", {awaddr, araddr}, 0);
    chk("rst_wdata", {wdata, wstrb}, 0);
    {busy, exp_rsp, b_pend, r_pend, wrote} = '0;
    last = 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int gi;
    int d0;
    int lim;
    {has[0], has[1]} = '0;
    {awready, wready, arready, bvalid, rvalid} = '0;
    {bresp, rresp} = '0;
    rdata = '0;
    do_reset();

    // single read from requester 0
    mem[32'h100] = 64'hDEADBEEF_CAFEF00D;
    has[0] = 1;
    swe[0] = 0;
    sa[0] = 32'h100;
    run_until(done + 1);
    chk("rd_araddr", last_ar, 32'h100);
    chk("rd_vec", last_vec, 2'b01);
    chk("rd_data", last_data, 64'hDEADBEEF_CAFEF00D);
    chk("rd_err", last_err, 0);

    // continuous contention alternates grants
    do_reset();
    gi = grants.size();
    refill = 1;
    run_until(done + 4);
    refill = 0;
    {has[0], has[1]} = '0;
    chk("rr_g0", grants[gi], 0);
    chk("rr_g1", grants[gi+1], 1);
    chk("rr_g2", grants[gi+2], 0);
    chk("rr_g3", grants[gi+3], 1);

    // error response on read
    f_resp = 2;
    has[0] = 1;
    swe[0] = 0;
    sa[0] = 32'h40;
    run_until(done + 1);
    chk("rerr_err", last_err, 1);
    chk("rerr_vec", last_vec, 2'b01);
    f_resp = 0;

    // write with W accepted 3 cycles before AW
    f_aw = 3;
    has[1] = 1;
    swe[1] = 1;
    sa[1] = 32'h80;
    sd[1] = 64'h0123_4567_89AB_CDEF;
    ss[1] = 8'hF0;
    run_until(done + 1);
    chk("wr_order", aw_cyc - w_cyc, 3);
    chk("wr_bhs", b_hs, 1);
    chk("wr_vec", last_vec, 2'b10);
    f_aw = 0;

    // reset while waiting for BVALID
    f_b = 20;
    has[0] = 1;
    swe[0] = 1;
    sa[0] = 32'h88;
    lim = 0;
    while (!bready && lim < 50) begin
      step();
      lim++;
    end
    chk("rstwr_reach", bready, 1);
    step();
    new_req(0);
    new_req(1);
    gi = grants.size();
    d0 = done;
    do_reset();
    f_b = 0;
    run_until(d0 + 1);
    chk("rstwr_tie", grants[gi], 0);

    // randomized traffic
    auto_req = 1;
    {f_aw, f_w, f_ar, f_b, f_r, f_resp} = {6{-1}};
    d0 = done;
    repeat (2000) step();
    chk("rand_progress", done > d0 + 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_mem_arbiter.md
AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 64, AXI and requester data width (DW).
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI and requester address width (AW).
REQ-003 SHALL have port M_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port M_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  2  per-requester request valid; bit i = requester i.
REQ-006 SHALL have port req_ready  out  2  per-requester request accept.
REQ-007 SHALL have port req_we  in  2  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  in  2*AW  requester i at bits [i*AW +: AW].
REQ-009 SHALL have port req_wdata  in  2*DW  requester i at bits [i*DW +: DW].
REQ-010 SHALL have port req_wstrb  in  2*DW/8  requester i at bits [i*DW/8 +: DW/8].
REQ-011 SHALL have port rsp_valid  out  2  one-cycle completion pulse to the owning requester.
REQ-012 SHALL have port rsp_rdata  out  DW  read data, valid with rsp_valid; 0 for writes.
REQ-013 SHALL have port rsp_err  out  1  1 when BRESP/RRESP != 2'b00, valid with rsp_valid.
REQ-014 SHALL have AXI4 single-beat master ports: M_AXI_AWADDR out AW; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1; M_AXI_WDATA out DW; M_AXI_WSTRB out DW/8; M_AXI_WVALID out 1; M_AXI_WREADY in 1; M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1; M_AXI_ARADDR out AW; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1; M_AXI_RDATA in DW; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1. LEN/SIZE/BURST/LAST are tied off outside this block (LEN=0).

Function
REQ-015 SHALL implement states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
REQ-016 In IDLE, SHALL drive req_ready combinationally high only for the granted requester g and only when req_valid[g]=1; all other states: req_ready=0.
REQ-017 Grant SHALL be round-robin: if exactly one requester is valid, grant it; if both are valid, grant the one not granted last; last-grant pointer updates only on accept.
REQ-018 On accept (valid&ready), SHALL register addr, wdata, wstrb, we, owner g; go to WR_ADDR_DATA if we=1, else RD_ADDR.
REQ-019 WR_ADDR_DATA: AWVALID and WVALID SHALL assert the cycle after accept; each SHALL drop independently on its own handshake; go to WR_RESP once both have completed, in either order or in the same cycle.
REQ-020 WR_RESP: BREADY=1; on BVALID, capture err=(BRESP!=0), rdata=0, go to RESP.
REQ-021 RD_ADDR: ARVALID=1 until ARREADY, then RD_DATA; RD_DATA: RREADY=1; on RVALID, capture RDATA and err=(RRESP!=0), go to RESP.
REQ-022 RESP: rsp_valid[g]=1 for exactly one cycle with rsp_rdata/rsp_err, then IDLE; a new accept is possible the next cycle.
REQ-023 AXI address/data/strobe outputs SHALL hold stable while the associated VALID is high.
REQ-024 BREADY/RREADY SHALL be 0 outside WR_RESP/RD_DATA; at most one transaction outstanding.
REQ-025 Requester input changes after accept SHALL NOT affect the in-flight transaction.

Reset
REQ-026 On M_AXI_ARESET=1, state=IDLE, all VALID/READY outputs=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, AXI addr/data/strb=0, last-grant pointer set so requester 0 wins the first tie.
REQ-027 Reset mid-transaction SHALL abandon it with no rsp_valid pulse.

Verification
REQ-028 Req0 read addr 0x100, AR/R ready immediately, RDATA=0xDEADBEEF_CAFEF00D -> ARADDR=0x100, rsp_valid=2'b01 with that data, rsp_err=0.
REQ-029 Both requesters valid continuously for 4 transactions -> grants alternate 0,1,0,1.
REQ-030 Req1 write, WREADY 3 cycles before AWREADY -> WVALID drops first, single BREADY handshake, rsp_valid=2'b10.
REQ-031 Read with RRESP=2'b10 -> rsp_err=1 with rsp_valid.
REQ-032 Reset asserted in WR_RESP -> next cycle all outputs 0, no rsp_valid; next tie grants requester 0.
